// File: rtl/mbadd_pkg.sv
// ============================================================================
// Module      : mbadd_pkg
// Description : Shared types and helpers for the multibyte add sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mbadd_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for a byte counter; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/eight_bit_adder.sv
// ============================================================================
// Module      : eight_bit_adder
// Description : Combinational 8-bit adder with carry-in and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eight_bit_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_i};

endmodule

`default_nettype wire

// File: rtl/multibyte_add_sequencer.sv
// ============================================================================
// Module      : multibyte_add_sequencer
// Description : Adds two NBYTES-wide operands one byte per cycle through a
//               single eight_bit_adder, with valid/ready on both sides.
//               Optional signed-overflow output: define MULTIBYTE_ADD_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multibyte_add_sequencer
    import mbadd_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy
`ifdef MULTIBYTE_ADD_OVF_EN
    ,
    output logic                  ovf
`endif
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t                          state_q, state_d;
    logic [NBYTES-1:0][BYTE_W-1:0]   a_q, a_d;
    logic [NBYTES-1:0][BYTE_W-1:0]   b_q, b_d;
    logic [NBYTES-1:0][BYTE_W-1:0]   work_q, work_d;
    logic [NBYTES-1:0][BYTE_W-1:0]   work_upd;
    logic [W-1:0]                    sum_q, sum_d;
    logic                            carry_q, carry_d;
    logic                            cout_q, cout_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [BYTE_W-1:0]               add_sum;
    logic                            add_carry;
`ifdef MULTIBYTE_ADD_OVF_EN
    logic                            ovf_q, ovf_d;
`endif

    eight_bit_adder u_adder (
        .a_i     (a_q[idx_q]),
        .b_i     (b_q[idx_q]),
        .cin_i   (carry_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        idx_d    = idx_q;
`ifdef MULTIBYTE_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        // Working vector with the current byte merged in, so the DONE-entry
        // load of sum sees the final byte produced on that same edge.
        work_upd        = work_q;
        work_upd[idx_q] = add_sum;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                work_d  = work_upd;
                carry_d = add_carry;
                if (idx_q == LAST_IDX) begin
                    sum_d   = work_upd;
                    cout_d  = add_carry;
`ifdef MULTIBYTE_ADD_OVF_EN
                    ovf_d   = (a_q[NBYTES-1][BYTE_W-1] == b_q[NBYTES-1][BYTE_W-1]) &&
                              (work_upd[NBYTES-1][BYTE_W-1] != a_q[NBYTES-1][BYTE_W-1]);
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef MULTIBYTE_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef MULTIBYTE_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Ready is gated by rst so it stays low for the whole reset window.
    assign start_ready = (state_q == IDLE) && !rst;
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign sum         = sum_q;
    assign cout        = cout_q;
`ifdef MULTIBYTE_ADD_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multibyte_add_sequencer.sv
// ============================================================================
// Module      : tb_multibyte_add_sequencer
// Description : Scoreboard bench for multibyte_add_sequencer (NBYTES=4).
//               Checks ovf as well when MULTIBYTE_ADD_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multibyte_add_sequencer;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef MULTIBYTE_ADD_OVF_EN
    logic         ovf;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .busy        (busy)
`ifdef MULTIBYTE_ADD_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain wide arithmetic and the signed-overflow rule.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (av[W-1] == bv[W-1]) && (e.s[W-1] != av[W-1]);
        return e;
    endfunction

    // Monitor: every result handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 64'(res_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum",  64'(sum),  64'(e.s));
                check("cout", 64'(cout), 64'(e.c));
`ifdef MULTIBYTE_ADD_OVF_EN
                check("ovf",  64'(ovf),  64'(e.o));
`endif
            end
        end
    end

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input int hold, input bit pulse);
        int   k;
        exp_t e;
        k = 0;
        while (!start_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("ready_before_op", 64'(start_ready), 64'd1);
        e = model(av, bv, ci);
        sb_q.push_back(e);
        a = av; b = bv; cin = ci; start_valid = 1'b1;
        res_ready = (hold == 0);
        @(posedge clk); #1;
        start_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        k = 0;
        while (!res_valid && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("latency", 64'(k), 64'(NBYTES));
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                start_valid = 1'b1;
                a = $urandom; b = $urandom; cin = 1'b1;
            end
            @(posedge clk); #1;
            check("hold_valid",  64'(res_valid),   64'd1);
            check("hold_sum",    64'(sum),         64'(e.s));
            check("hold_cout",   64'(cout),        64'(e.c));
            check("hold_nready", 64'(start_ready), 64'd0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("ready_after_hs", 64'(start_ready), 64'd1);
        check("valid_after_hs", 64'(res_valid),   64'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst_start_ready", 64'(start_ready), 64'd0);
        check("rst_res_valid",   64'(res_valid),   64'd0);
        check("rst_sum",         64'(sum),         64'd0);
        check("rst_cout",        64'(cout),        64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("ready_after_rst", 64'(start_ready), 64'd1);

        do_op(32'd100,        32'd100,        1'b1, 0, 1'b0);
        do_op(32'h0000_00FF,  32'h0000_0001,  1'b0, 0, 1'b0);
        do_op(32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 0, 1'b0);
        do_op(32'h7FFF_FFFF,  32'h0000_0001,  1'b0, 0, 1'b0);
        do_op(32'h8000_0000,  32'h8000_0000,  1'b1, 0, 1'b0);
        do_op(32'h1234_5678,  32'h8765_4321,  1'b0, 5, 1'b1);
        check("no_extra_op", 64'(busy), 64'd0);

        for (int n = 0; n < 20; n++) begin
            do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // Abort an operation two cycles into ADD with an asynchronous reset.
        @(posedge clk); #1;
        a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_res_valid",   64'(res_valid),   64'd0);
        check("abort_sum",         64'(sum),         64'd0);
        check("abort_cout",        64'(cout),        64'd0);
        check("abort_busy",        64'(busy),        64'd0);
        check("abort_start_ready", 64'(start_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1 check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/multibyte_add_sequencer.md
Name: multibyte_add_sequencer

Overview:
Upstream operand sequencer and carry-chain controller for the existing eight_bit_adder. It accepts two NBYTES-wide operands and a carry-in over a valid/ready handshake. It adds them one byte per cycle, LSB first, through a single eight_bit_adder instance, chaining the carry through a register. It then presents the full-width sum and carry-out on a valid/ready result port.

Parameters:
NBYTES, 4, number of byte slices per operand; legal range 1..16.
W, 8*NBYTES, derived operand/result width; not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start_valid  input  1  operand request
start_ready  output  1  block can accept operands
a  input  W  operand A, sampled on accept
b  input  W  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
res_valid  output  1  result available
res_ready  input  1  consumer takes result
sum  output  W  result sum
cout  output  1  final carry-out
busy  output  1  high in ADD or DONE

Behaviour:
- One clock; reset is asynchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset values: state=IDLE, res_valid=0, sum=0, cout=0, busy=0, byte index=0, carry reg=0, operand regs=0.
- While rst is high, start_ready=0. After rst is released, start_ready=1 (IDLE).
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start_ready=1.
  - Accept occurs when start_valid && start_ready. On accept: latch a, b; carry_reg<=cin; idx<=0; go to ADD.
- ADD:
  - Each cycle, the adder gets a_reg[idx*8+:8], b_reg[idx*8+:8], carry_reg.
  - On the clock edge: work_reg[idx*8+:8]<=Sum; carry_reg<=Carry; idx<=idx+1.
  - When idx==NBYTES-1, go to DONE instead of incrementing.
- DONE:
  - res_valid=1. sum and cout are loaded from work_reg/carry_reg on the DONE-entry edge.
  - Hold until res_ready. On res_valid && res_ready: res_valid<=0 and return to IDLE.
  - start_ready rises the cycle after the handshake; there is no same-cycle turnaround.
- Latency: accept edge at cycle 0 gives res_valid high after NBYTES edges (cycle NBYTES). Throughput is one operation per NBYTES+2 cycles minimum.
- sum and cout hold the last result until the next DONE entry. They are meaningful only while res_valid=1.
- res_ready asserted before res_valid is ignored.
- start_valid in ADD or DONE is ignored; start_ready=0 there.
- Width rules:
  - Sum is modulo 2^W.
  - cout is the carry out of byte NBYTES-1.
  - With NBYTES=1, the block behaves as a registered eight_bit_adder with handshake and latency 1.
- Reset mid-operation: the operation is aborted immediately and no result is produced. All registers return to reset values, and the next accepted operation computes correctly.
- No combinational path from start_valid to start_ready, or from res_ready to res_valid.

Optional Feature:
Macro: MULTIBYTE_ADD_OVF_EN
- Defined: extra output port ovf (1 bit), reset 0. It is loaded on DONE entry with the signed two's-complement overflow of the full-width add: (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]). It holds with sum.
- Undefined: no ovf port and no related logic.

Decomposition:
- Shared package mbadd_pkg:
  - typedef state_t enum {IDLE, ADD, DONE}
  - localparam BYTE_W=8
  - function clog2 for the index width: max(1, clog2(NBYTES))
- Sub-module: the existing eight_bit_adder, instantiated once as the datapath. No new sub-module is needed.

Test Plan:
- NBYTES=4: a=100, b=100, cin=1 -> sum=201, cout=0. res_valid rises exactly 4 cycles after the accept edge.
- a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0. Checks the inter-byte carry register.
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1. Carry ripples through all 4 bytes.
- Backpressure: complete an op with res_ready=0 for 5 cycles while pulsing start_valid -> res_valid, sum, cout stable; start_ready=0; no second op accepted. res_ready=1 -> handshake, then start_ready=1 next cycle.
- Assert rst asynchronously (mid-cycle) 2 cycles into ADD with a=0x12345678, b=0x11111111 -> all outputs 0 immediately. After release, a=0xDEADBEEF, b=0x21524111, cin=0 -> sum=0x00000000, cout=1.
- With MULTIBYTE_ADD_OVF_EN: a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1, cout=0. a=0xFFFFFFFF, b=1 -> ovf=0, cout=1.
